rhs_stim_axil_regs: RTL and testbench

AXI4-Lite responder (slave) holding the RHS stimulation/recording controller configuration. It is the register file driven by host software or an AXI master over AXI4-Lite. It decodes writes and reads, applies byte strobes, and presents registered configuration fields to the RHS sequencer. Mode bits in the control register are converted into single-cycle command pulses.

---
 rtl/rhs_stim_axil_regs.sv | 202 ++++++++++++++++++++
 tb/tb_rhs_stim_axil_regs.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rhs_stim_axil_regs.sv
// AXI4-Lite register file for the RHS stimulation/recording controller.
// Holds sequencer configuration and turns CTRL mode bits into command pulses.
module rhs_stim_axil_regs #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CH_BITS    = 5
) (
  input  logic                    rhs_aclk,
  input  logic                    rhs_areset,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]              s_axi_awprot,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]              s_axi_arprot,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [31:0]             stim_mag,
  output logic [15:0]             pkt_len,
  output logic [7:0]              zc_cycle,
  output logic [1:0]              zc_scale,
  output logic [CH_BITS-1:0]      stim_pos_ch,
  output logic [CH_BITS-1:0]      stim_neg_ch,
  output logic                    stim_mono,
  output logic [15:0]             pulse_width,
  output logic [15:0]             ipd,
  output logic [7:0]              num_pulse,
  output logic                    loopback,
  output logic                    stim_en,
  output logic                    init_pulse,
  output logic                    mag_pulse,
  input  logic                    seq_busy,
  input  logic                    stim_active
);

  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlverr = 2'b10;
  localparam logic [1:0]  RespDecerr = 2'b11;
  localparam logic [3:0]  IdxStatus  = 4'd8;
  localparam logic [3:0]  IdxMagic   = 4'd9;
  localparam logic [31:0] Magic      = 32'h5248_5331;
  localparam logic [31:0] ChanMask   = 32'((64'd1 << (2 * CH_BITS + 1)) - 64'd1);

  function automatic logic [31:0] field_mask(input logic [2:0] idx);
    case (idx)
      3'd0:    field_mask = 32'h0000_003F;
      3'd1:    field_mask = 32'hFFFF_FFFF;
      3'd2:    field_mask = 32'h0000_FFFF;
      3'd3:    field_mask = 32'h0000_03FF;
      3'd4:    field_mask = ChanMask;
      3'd5:    field_mask = 32'h0000_FFFF;
      3'd6:    field_mask = 32'h0000_FFFF;
      default: field_mask = 32'h0000_00FF;
    endcase
  endfunction

  logic        ready_q;
  logic        aw_full_q, w_full_q, bvalid_q, rvalid_q, err_q;
  logic [3:0]  aw_idx_q;
  logic [31:0] w_data_q, rdata_q;
  logic [3:0]  w_strb_q;
  logic [1:0]  bresp_q, rresp_q, ctrl_dly_q;
  logic        init_pulse_q, mag_pulse_q;
  logic [31:0] cfg_q [8];

  logic        wr_fire, wr_store, wr_err_set, wr_err_clr;
  logic [1:0]  wr_resp, rd_resp;
  logic [31:0] strb_mask, wr_merged, rd_data;
  logic [3:0]  rd_idx;
  logic        unused_bits;

  assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign s_axi_awready = ready_q & ~aw_full_q & ~bvalid_q;
  assign s_axi_wready  = ready_q & ~w_full_q & ~bvalid_q;
  assign s_axi_arready = ready_q & ~rvalid_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;

  assign wr_fire   = aw_full_q & w_full_q & ~bvalid_q;
  assign strb_mask = {{8{w_strb_q[3]}}, {8{w_strb_q[2]}}, {8{w_strb_q[1]}}, {8{w_strb_q[0]}}};
  assign wr_merged = ((cfg_q[aw_idx_q[2:0]] & ~strb_mask) | (w_data_q & strb_mask))
                     & field_mask(aw_idx_q[2:0]);
  assign rd_idx    = s_axi_araddr[5:2];

  // CTRL stays writable under stim_active so software can always stop stimulation.
  always_comb begin
    wr_resp    = RespOkay;
    wr_store   = 1'b0;
    wr_err_set = 1'b0;
    wr_err_clr = 1'b0;
    if (!aw_idx_q[3]) begin
      if (aw_idx_q == 4'd0) begin
        wr_store   = 1'b1;
        wr_err_clr = w_strb_q[3] & w_data_q[31];
      end else if (stim_active) begin
        wr_resp = RespSlverr;
      end else begin
        wr_store = 1'b1;
      end
    end else if (aw_idx_q == IdxStatus || aw_idx_q == IdxMagic) begin
      wr_resp    = RespSlverr;
      wr_err_set = 1'b1;
    end else begin
      wr_resp = RespDecerr;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_resp = RespOkay;
    if (!rd_idx[3])               rd_data = cfg_q[rd_idx[2:0]];
    else if (rd_idx == IdxStatus) rd_data = {29'd0, err_q, stim_active, seq_busy};
    else if (rd_idx == IdxMagic)  rd_data = Magic;
    else                          rd_resp = RespDecerr;
  end

  always_ff @(posedge rhs_aclk) begin
    if (rhs_areset) begin
      ready_q      <= 1'b0;
      aw_full_q    <= 1'b0;
      w_full_q     <= 1'b0;
      bvalid_q     <= 1'b0;
      rvalid_q     <= 1'b0;
      err_q        <= 1'b0;
      aw_idx_q     <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      rdata_q      <= '0;
      bresp_q      <= RespOkay;
      rresp_q      <= RespOkay;
      ctrl_dly_q   <= '0;
      init_pulse_q <= 1'b0;
      mag_pulse_q  <= 1'b0;
      for (int i = 0; i < 8; i++) cfg_q[i] <= (i == 2) ? 32'd1 : 32'd0;
    end else begin
      ready_q <= 1'b1;
      if (s_axi_awvalid && s_axi_awready) begin
        aw_full_q <= 1'b1;
        aw_idx_q  <= s_axi_awaddr[5:2];
      end
      if (s_axi_wvalid && s_axi_wready) begin
        w_full_q <= 1'b1;
        w_data_q <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb;
      end
      if (wr_fire) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_resp;
        if (wr_store) cfg_q[aw_idx_q[2:0]] <= wr_merged;
        if (wr_err_set)      err_q <= 1'b1;
        else if (wr_err_clr) err_q <= 1'b0;
      end
      if (bvalid_q && s_axi_bready) begin
        bvalid_q  <= 1'b0;
        aw_full_q <= 1'b0;
        w_full_q  <= 1'b0;
      end
      // Read data is captured at accept, so a same-cycle write is not yet visible.
      if (s_axi_arvalid && s_axi_arready) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
        rresp_q  <= rd_resp;
      end else if (rvalid_q && s_axi_rready) begin
        rvalid_q <= 1'b0;
      end
      ctrl_dly_q   <= cfg_q[0][2:1];
      init_pulse_q <= cfg_q[0][1] & ~ctrl_dly_q[0];
      mag_pulse_q  <= cfg_q[0][2] & ~ctrl_dly_q[1];
    end
  end

  assign stim_mag    = cfg_q[1];
  assign pkt_len     = cfg_q[2][15:0];
  assign zc_cycle    = cfg_q[3][7:0];
  assign zc_scale    = cfg_q[3][9:8];
  assign stim_pos_ch = cfg_q[4][CH_BITS-1:0];
  assign stim_neg_ch = cfg_q[4][2*CH_BITS-1:CH_BITS];
  assign stim_mono   = cfg_q[4][2*CH_BITS];
  assign pulse_width = cfg_q[5][15:0];
  assign ipd         = cfg_q[6][15:0];
  assign num_pulse   = cfg_q[7][7:0];
  assign loopback    = cfg_q[0][5];
  assign stim_en     = cfg_q[0][3];
  assign init_pulse  = init_pulse_q;
  assign mag_pulse   = mag_pulse_q;

endmodule

// File: tb/tb_rhs_stim_axil_regs.sv
// Bench for rhs_stim_axil_regs: vector table, handshake corner cases and a
// randomized phase checked against a register-map model.
module tb_rhs_stim_axil_regs;

  localparam int Wait = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [31:0] stim_mag;
  logic [15:0] pkt_len, pulse_width, ipd;
  logic [7:0]  zc_cycle, num_pulse;
  logic [1:0]  zc_scale;
  logic [4:0]  stim_pos_ch, stim_neg_ch;
  logic        stim_mono, loopback, stim_en, init_pulse, mag_pulse;
  logic        seq_busy = 1'b0, stim_active = 1'b0;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [1:0]  pulses_at_b;
  logic [31:0] mdl [8];
  logic        mdl_err;

  always #5 clk = ~clk;

  rhs_stim_axil_regs #(.ADDR_WIDTH(6), .DATA_WIDTH(32), .CH_BITS(5)) dut (
    .rhs_aclk(clk), .rhs_areset(rst),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid),
    .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid),
    .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .stim_mag(stim_mag), .pkt_len(pkt_len), .zc_cycle(zc_cycle), .zc_scale(zc_scale),
    .stim_pos_ch(stim_pos_ch), .stim_neg_ch(stim_neg_ch), .stim_mono(stim_mono),
    .pulse_width(pulse_width), .ipd(ipd), .num_pulse(num_pulse),
    .loopback(loopback), .stim_en(stim_en), .init_pulse(init_pulse), .mag_pulse(mag_pulse),
    .seq_busy(seq_busy), .stim_active(stim_active)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: no handshake within %0d cycles", name, Wait);
  endtask

  // Completes whatever AW/W is being driven, then holds bready low b_delay cycles.
  task automatic wr_finish(input int b_delay, output logic [1:0] resp);
    int n;
    logic aw_hs, w_hs;
    n = 0;
    bready = 1'b0;
    while ((awvalid || wvalid) && n < Wait) begin
      aw_hs = awvalid & awready;
      w_hs  = wvalid & wready;
      @(negedge clk);
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid  = 1'b0;
      n++;
    end
    while (!bvalid && n < Wait) begin
      @(negedge clk);
      n++;
    end
    if (n >= Wait) begin
      timeout("write");
      awvalid = 1'b0;
      wvalid  = 1'b0;
      resp    = 2'bxx;
    end else begin
      pulses_at_b = {mag_pulse, init_pulse};
      for (int i = 0; i < b_delay; i++) begin
        check("b_stall", {29'd0, bvalid, awready, wready}, 32'b100);
        @(negedge clk);
      end
      resp   = bresp;
      bready = 1'b1;
      @(negedge clk);
      bready = 1'b0;
    end
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int b_delay, output logic [1:0] resp);
    @(negedge clk);
    awaddr  = a;
    wdata   = d;
    wstrb   = s;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    wr_finish(b_delay, resp);
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    logic hs;
    @(negedge clk);
    araddr  = a;
    arvalid = 1'b1;
    rready  = 1'b0;
    n = 0;
    while (arvalid && n < Wait) begin
      hs = arready;
      @(negedge clk);
      if (hs) arvalid = 1'b0;
      n++;
    end
    while (!rvalid && n < Wait) begin
      @(negedge clk);
      n++;
    end
    if (n >= Wait) begin
      timeout("read");
      arvalid = 1'b0;
      d = 'x;
      resp = 2'bxx;
    end else begin
      d      = rdata;
      resp   = rresp;
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
    end
  endtask

  // Register map model: field widths per word, byte-lane merge, lock and error rules.
  function automatic logic [31:0] field_mask(input int idx);
    int w;
    case (idx)
      0: w = 6;   1: w = 32;  2: w = 16;  3: w = 10;
      4: w = 11;  5: w = 16;  6: w = 16;  default: w = 8;
    endcase
    return 32'((64'd1 << w) - 64'd1);
  endfunction

  task automatic mdl_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic active, output logic [1:0] resp);
    int idx;
    logic [31:0] v;
    idx  = int'(a) / 4;
    resp = 2'b00;
    if (idx <= 7) begin
      if (idx != 0 && active) begin
        resp = 2'b10;
      end else begin
        v = mdl[idx];
        for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
        mdl[idx] = v & field_mask(idx);
        if (idx == 0 && s[3] && d[31]) mdl_err = 1'b0;
      end
    end else if (idx == 8 || idx == 9) begin
      resp    = 2'b10;
      mdl_err = 1'b1;
    end else begin
      resp = 2'b11;
    end
  endtask

  task automatic mdl_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
    int idx;
    idx  = int'(a) / 4;
    resp = 2'b00;
    d    = 32'd0;
    if (idx <= 7)       d = mdl[idx];
    else if (idx == 8)  d = {29'd0, mdl_err, stim_active, seq_busy};
    else if (idx == 9)  d = 32'h5248_5331;
    else                resp = 2'b11;
  endtask

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  bresp;
    logic [31:0] rdata;
    logic [1:0]  rresp;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [1:0]  r, r2;
    logic [31:0] d;
    logic        seen;

    vecs[0] = '{6'h04, 32'h80FF_80FF, 4'hF, 2'b00, 32'h80FF_80FF, 2'b00};
    vecs[1] = '{6'h08, 32'hDEAD_1234, 4'h3, 2'b00, 32'h0000_1234, 2'b00};
    vecs[2] = '{6'h08, 32'h0000_5600, 4'h2, 2'b00, 32'h0000_5634, 2'b00};
    vecs[3] = '{6'h0C, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'h0000_03FF, 2'b00};
    vecs[4] = '{6'h10, 32'hFFFF_F7FF, 4'hF, 2'b00, 32'h0000_07FF, 2'b00};
    vecs[5] = '{6'h14, 32'h0001_ABCD, 4'hF, 2'b00, 32'h0000_ABCD, 2'b00};
    vecs[6] = '{6'h18, 32'hFFFF_FFFF, 4'h0, 2'b00, 32'h0000_0000, 2'b00};
    vecs[7] = '{6'h1C, 32'h1234_5678, 4'h1, 2'b00, 32'h0000_0078, 2'b00};
    vecs[8] = '{6'h2C, 32'h1234_5678, 4'hF, 2'b11, 32'h0000_0000, 2'b11};
    vecs[9] = '{6'h1E, 32'h0000_9900, 4'h2, 2'b00, 32'h0000_0078, 2'b00};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready_valid", {27'd0, awready, wready, arready, bvalid, rvalid}, 32'd0);
    check("rst_resp_rdata", {bresp, rresp, rdata[27:0]}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {29'd0, awready, wready, arready}, 32'b111);
    check("rst_pkt_len", pkt_len, 32'd1);
    check("rst_cfg", {stim_mag, num_pulse, loopback, stim_en, init_pulse, mag_pulse}, 44'd0);
    axi_read(6'h24, d, r);
    check("magic", d, 32'h5248_5331);

    // Vector table
    for (int i = 0; i < 10; i++) begin
      axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, r);
      check($sformatf("vec%0d_bresp", i), r, vecs[i].bresp);
      axi_read(vecs[i].addr, d, r);
      check($sformatf("vec%0d_rdata", i), d, vecs[i].rdata);
      check($sformatf("vec%0d_rresp", i), r, vecs[i].rresp);
    end
    check("out_fields", {stim_mag, pkt_len, zc_cycle, 6'd0, zc_scale},
          {32'h80FF_80FF, 16'h5634, 8'hFF, 8'h03});
    check("out_chan", {stim_pos_ch, stim_neg_ch, stim_mono}, 11'h7FF);
    check("out_timing", {pulse_width, ipd, num_pulse}, {16'hABCD, 16'h0000, 8'h78});

    // W arrives three cycles ahead of AW
    @(negedge clk);
    wdata = 32'h0000_0232; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    seen = 1'b0;
    repeat (2) begin
      seen |= bvalid | wready;
      @(negedge clk);
    end
    check("w_first_no_early_b", {31'd0, seen}, 32'd0);
    awaddr = 6'h10; awvalid = 1'b1;
    wr_finish(0, r);
    check("w_first_bresp", r, 2'b00);
    seen = 1'b0;
    repeat (3) begin
      seen |= bvalid;
      @(negedge clk);
    end
    check("w_first_single_b", {31'd0, seen}, 32'd0);
    check("w_first_chan", {stim_pos_ch, stim_neg_ch, stim_mono}, {5'd18, 5'd17, 1'b0});

    // CTRL mode bits to pulses
    axi_write(6'h00, 32'h23, 4'hF, 0, r);
    check("ctrl23_no_pulse_at_b", pulses_at_b, 2'b00);
    check("ctrl23_pulses", {loopback, mag_pulse, init_pulse}, 3'b101);
    @(negedge clk);
    check("init_one_cycle", {mag_pulse, init_pulse}, 2'b00);
    axi_write(6'h00, 32'h00, 4'hF, 0, r);
    check("ctrl00_pulses", {loopback, mag_pulse, init_pulse}, 3'b000);
    axi_write(6'h00, 32'h25, 4'hF, 0, r);
    check("ctrl25_pulses", {mag_pulse, init_pulse}, 2'b10);
    axi_write(6'h00, 32'h25, 4'hF, 0, r);
    check("ctrl25_again", {pulses_at_b, mag_pulse, init_pulse}, 4'b0000);

    // B held off ten cycles while a second write waits
    fork
      axi_write(6'h18, 32'h0000_1111, 4'hF, 10, r);
      begin
        repeat (3) @(negedge clk);
        awaddr = 6'h1C; wdata = 32'h42; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      end
    join
    check("stall_first_ok", {r, ipd}, {2'b00, 16'h1111});
    check("stall_second_held", num_pulse, 32'h78);
    wr_finish(0, r2);
    check("stall_second_done", {r2, num_pulse}, {2'b00, 8'h42});

    // Decode errors and sticky error bit
    axi_read(6'h28, d, r);
    check("decerr_read", {r, d[29:0]}, {2'b11, 30'd0});
    axi_write(6'h20, 32'hFFFF_FFFF, 4'hF, 0, r);
    check("ro_write_slverr", r, 2'b10);
    axi_read(6'h20, d, r);
    check("status_err_set", d, 32'h4);
    axi_write(6'h00, 32'h8000_0000, 4'hF, 0, r);
    axi_read(6'h20, d, r);
    check("status_err_clr", {r, d}, {2'b00, 32'h0});
    axi_read(6'h00, d, r);
    check("ctrl_bit31_not_stored", d, 32'h0);

    // Config lock
    axi_write(6'h00, 32'h08, 4'hF, 0, r);
    check("stim_en_set", stim_en, 1'b1);
    axi_write(6'h14, 32'h1234, 4'hF, 0, r);
    stim_active = 1'b1;
    axi_write(6'h14, 32'h5, 4'hF, 0, r);
    check("lock_slverr", {r, pulse_width}, {2'b10, 16'h1234});
    axi_write(6'h00, 32'h00, 4'hF, 0, r);
    check("lock_ctrl_ok", {r, 1'b0, stim_en}, 4'b0000);
    stim_active = 1'b0;

    // Read accepted on the write's update edge returns the old value
    fork
      axi_write(6'h04, 32'hA5A5_0000, 4'hF, 0, r);
      begin
        @(negedge clk);
        axi_read(6'h04, d, r2);
      end
    join
    check("rw_same_cycle_old", d, 32'h80FF_80FF);
    axi_read(6'h04, d, r2);
    check("rw_after_new", d, 32'hA5A5_0000);

    // Reset between accept and update drops the write
    @(negedge clk);
    awaddr = 6'h04; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      seen |= bvalid;
      @(negedge clk);
    end
    bready = 1'b0;
    check("midreset_no_b", {31'd0, seen}, 32'd0);
    check("midreset_cfg", stim_mag, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 8; i++) mdl[i] = (i == 2) ? 32'd1 : 32'd0;
    mdl_err = 1'b0;
    for (int it = 0; it < 300; it++) begin
      logic [5:0]  a;
      logic [31:0] dd, ed;
      logic [3:0]  s;
      logic [1:0]  er;
      a           = 6'($urandom_range(0, 63));
      dd          = $urandom;
      s           = 4'($urandom_range(0, 15));
      stim_active = ($urandom_range(0, 3) == 0);
      seq_busy    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) begin
        mdl_write(a, dd, s, stim_active, er);
        axi_write(a, dd, s, 0, r);
        check("rnd_bresp", r, er);
        check("rnd_stim_mag", stim_mag, mdl[1]);
        check("rnd_pkt_num", {pkt_len, num_pulse}, {mdl[2][15:0], mdl[7][7:0]});
      end else begin
        mdl_read(a, ed, er);
        axi_read(a, d, r);
        check("rnd_rdata", d, ed);
        check("rnd_rresp", r, er);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
